// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared core constants for the register-file writeback scheduler.
// Defaults for the datapath geometry and the requester indices used by the arbiter.
package regfile_wb_scheduler_pkg;

  localparam int REG_COUNT_DEF  = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;

  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_LSU = 1'b1
  } last_grant_e;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter: grant is combinational from the requests and the
// last-granted pointer, which only moves when the granted request is accepted.
module rr_arbiter_2
  import regfile_wb_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  last_grant_e last_r;

  // Grant selection; on contention favour whoever did not win last time
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (last_r == LAST_LSU) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end
      default: grant = 2'b00;
    endcase
  end

  // Pointer register, reset so that the ALU requester wins the first contention
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r <= LAST_LSU;
    end else if (advance) begin
      last_r <= grant[REQ_LSU] ? LAST_LSU : LAST_ALU;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates ALU and load writebacks onto a single registered register-file write
// port and tracks in-flight destinations in a pending scoreboard for hazard queries.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int REG_COUNT  = REG_COUNT_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb0_valid,
  input  logic [ADDR_WIDTH-1:0] wb0_rd,
  input  logic [DATA_WIDTH-1:0] wb0_data,
  output logic                  wb0_ready,
  input  logic                  wb1_valid,
  input  logic [ADDR_WIDTH-1:0] wb1_rd,
  input  logic [DATA_WIDTH-1:0] wb1_data,
  output logic                  wb1_ready,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [REG_COUNT-1:0]  pending
);

  logic [1:0]            grant_s;
  logic                  transfer_s;
  logic [ADDR_WIDTH-1:0] sel_rd_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic [REG_COUNT-1:0]  set_mask_s;
  logic [REG_COUNT-1:0]  clear_mask_s;
  logic [REG_COUNT-1:0]  pending_next_s;
  logic [REG_COUNT-1:0]  pending_r;
  logic                  rf_write_enable_r;
  logic [ADDR_WIDTH-1:0] rf_rd_r;
  logic [DATA_WIDTH-1:0] rf_write_data_r;

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({wb1_valid, wb0_valid}),
    .advance (transfer_s),
    .grant   (grant_s)
  );

  assign wb0_ready       = grant_s[REQ_ALU];
  assign wb1_ready       = grant_s[REQ_LSU];
  assign transfer_s      = |grant_s;
  assign rf_write_enable = rf_write_enable_r;
  assign rf_rd           = rf_rd_r;
  assign rf_write_data   = rf_write_data_r;
  assign pending         = pending_r;
  assign rs1_busy        = pending_r[rs1];
  assign rs2_busy        = pending_r[rs2];

  // Route the granted requester onto the write path
  always_comb begin
    sel_rd_s   = wb0_rd;
    sel_data_s = wb0_data;
    if (grant_s[REQ_LSU]) begin
      sel_rd_s   = wb1_rd;
      sel_data_s = wb1_data;
    end else begin
      sel_rd_s   = wb0_rd;
      sel_data_s = wb0_data;
    end
  end

  // Scoreboard next state: clear on the write edge, then set on issue so set wins
  always_comb begin
    set_mask_s   = {REG_COUNT{1'b0}};
    clear_mask_s = {REG_COUNT{1'b0}};
    if (issue_valid && (issue_rd != {ADDR_WIDTH{1'b0}})) begin
      set_mask_s[issue_rd] = 1'b1;
    end else begin
      set_mask_s = {REG_COUNT{1'b0}};
    end
    if (rf_write_enable_r) begin
      clear_mask_s[rf_rd_r] = 1'b1;
    end else begin
      clear_mask_s = {REG_COUNT{1'b0}};
    end
    pending_next_s    = (pending_r & ~clear_mask_s) | set_mask_s;
    pending_next_s[0] = 1'b0;
  end

  // Registered write port; x0 transfers are consumed without a write
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_enable_r <= 1'b0;
      rf_rd_r           <= {ADDR_WIDTH{1'b0}};
      rf_write_data_r   <= {DATA_WIDTH{1'b0}};
    end else if (transfer_s && (sel_rd_s != {ADDR_WIDTH{1'b0}})) begin
      rf_write_enable_r <= 1'b1;
      rf_rd_r           <= sel_rd_s;
      rf_write_data_r   <= sel_data_s;
    end else begin
      rf_write_enable_r <= 1'b0;
      rf_rd_r           <= rf_rd_r;
      rf_write_data_r   <= rf_write_data_r;
    end
  end

  // Pending scoreboard register
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= {REG_COUNT{1'b0}};
    end else begin
      pending_r <= pending_next_s;
    end
  end

endmodule

// File: doc/regfile_wb_scheduler.md
REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 The block SHALL have parameter REG_COUNT, default 32, number of architectural registers.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-004 The block SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have ports wb0_valid in 1, wb0_rd in ADDR_WIDTH, wb0_data in DATA_WIDTH, wb0_ready out 1, requester 0 (ALU writeback).
REQ-007 The block SHALL have ports wb1_valid in 1, wb1_rd in ADDR_WIDTH, wb1_data in DATA_WIDTH, wb1_ready out 1, requester 1 (load writeback).
REQ-008 The block SHALL have ports rf_write_enable out 1, rf_rd out ADDR_WIDTH, rf_write_data out DATA_WIDTH, the register file write port, all registered.
REQ-009 The block SHALL have ports issue_valid in 1, issue_rd in ADDR_WIDTH, marking a destination as pending when an instruction issues.
REQ-010 The block SHALL have ports rs1 in ADDR_WIDTH, rs2 in ADDR_WIDTH, rs1_busy out 1, rs2_busy out 1, the combinational hazard query.
REQ-011 The block SHALL have port pending out REG_COUNT, the scoreboard bitmap (bit i = register i pending).

Function
REQ-012 A transfer on requester k SHALL occur in a cycle where wbk_valid and wbk_ready are both high; wbk_ready SHALL be combinational from the valids and the arbitration state.
REQ-013 With exactly one valid requester, its ready SHALL be high; with none valid, both readies SHALL be low.
REQ-014 With both requesters valid, grant SHALL go to the requester not granted in the most recent transfer (round-robin); the other's ready SHALL be low.
REQ-015 The last-granted pointer SHALL update only on a transfer cycle.
REQ-016 A transfer in cycle N SHALL drive rf_write_enable=1, rf_rd=wbk_rd, rf_write_data=wbk_data in cycle N+1 (latency 1); with no transfer in cycle N, rf_write_enable SHALL be 0 in N+1.
REQ-017 rf_rd and rf_write_data SHALL hold their last values when rf_write_enable is 0.
REQ-018 A transfer with wbk_rd=0 SHALL be accepted (ready honoured, pointer updated) but SHALL produce rf_write_enable=0.
REQ-019 issue_valid with issue_rd!=0 SHALL set pending[issue_rd] at the next edge; issue_rd=0 SHALL be ignored; pending[0] SHALL always be 0.
REQ-020 pending[rf_rd] SHALL clear at the edge ending a cycle with rf_write_enable=1 (same edge the register file captures the data).
REQ-021 When issue and clear target the same register in one cycle, set SHALL win (pending stays 1).
REQ-022 Issue to an already-pending register SHALL leave it pending (single bit, no count).
REQ-023 rsN_busy SHALL equal pending[rsN] combinationally; no bypass of in-flight writeback data.
REQ-024 Writeback to a non-pending register SHALL still be written; pending is unaffected.

Reset
REQ-025 While reset is high at an edge: pending<=0, rf_write_enable<=0, rf_rd<=0, rf_write_data<=0, pointer<=requester 1 last granted (requester 0 wins first contention).
REQ-026 Reset SHALL dominate all other inputs in the same cycle; a transfer accepted in the cycle before reset SHALL be dropped (no write after reset).
REQ-027 wb0_ready/wb1_ready SHALL follow REQ-012..014 from the reset pointer state; no extra reset gating.

Structure
REQ-028 REG_COUNT/DATA_WIDTH/ADDR_WIDTH defaults and requester index constants (REQ_ALU=0, REQ_LSU=1) SHALL live in the shared core package.
REQ-029 Round-robin grant logic SHALL be a sub-module rr_arbiter_2 (two requests, grant vector, pointer register, advance-on-accept input).
REQ-030 The scoreboard SHALL be coded inline in regfile_wb_scheduler; no other sub-modules.

Verification
REQ-031 Single requester: wb0 valid rd=5 data=0xDEADBEEF cycle 3 -> wb0_ready=1 cycle 3; rf_write_enable=1, rf_rd=5, rf_write_data=0xDEADBEEF cycle 4 only.
REQ-032 Contention after reset: both valid rd=3/rd=7 held 3 cycles -> grants 0,1,0; writes rd=3,7,3 in cycles +1..+3.
REQ-033 Scoreboard: issue rd=9 -> rs1=9 gives rs1_busy=1 next cycle; wb1 rd=9 transfer -> busy clears at edge after rf_write_enable cycle.
REQ-034 Collision: issue rd=4 in same cycle rf_write_enable=1, rf_rd=4 -> pending[4] remains 1.
REQ-035 x0: issue rd=0 and wb0 rd=0 -> pending stays 0, wb0_ready=1, rf_write_enable=0.
REQ-036 Reset mid-op: transfer rd=12 in cycle N, reset high in N+1 -> rf_write_enable=0 after, pending all 0, next contention grants requester 0.
